uart_tx_arbiter: RTL and testbench



---
 rtl/uart_arb_pkg.sv | 16 +
 rtl/rr_priority_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter.
//   arb_state_t : byte sequencing state (IDLE -> START -> BUSY -> IDLE)
//   idx_width() : bit width of an index into n requesters (at least 1)
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker.
//   req : request vector, one bit per requester
//   ptr : highest-priority index; the scan runs ptr, ptr+1, ... modulo N
//   idx : first requesting index found by the scan (0 when none)
//   any : at least one request is present
module rr_priority_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int unsigned pos;
        pos = 0;
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(ptr) + k) % N;
            if (!any && req[IDX_W'(pos)]) begin
                any = 1'b1;
                idx = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// producers, with per-requester frame locking and a lock idle timeout.
//   clock, resetn : system clock, asynchronous active-low reset
//   req_valid     : requester i has a byte
//   req_data      : byte of requester i at [i*WIDTH +: WIDTH]
//   req_last      : byte ends requester i's frame
//   req_ready     : one-hot capture strobe (valid & ready = byte taken)
//   tx_data       : word to the transmitter, held until the next capture
//   tx_start      : start request, held until the transmitter goes not-ready
//   tx_ready      : transmitter idle
//   tx_done       : transmitter finished a byte (debug counting only)
//   grant_id      : current or last granted requester
//   locked        : a frame is in progress
//   busy          : sequencer is not IDLE
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned LOCK_IDLE_MAX = 16
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           tx_data,
    output logic                       tx_start,
    input  logic                       tx_ready,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       locked,
    output logic                       busy
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(LOCK_IDLE_MAX + 1);

    arb_state_t       state, state_nx;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] sel;
    logic             pick_any;
    logic             cand_valid;
    logic             capture;
    logic [CNT_W-1:0] idle_cnt;
    logic [15:0]      done_seen;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_priority_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // While locked only the lock owner is a candidate; other requesters wait.
    always_comb begin
        sel        = locked ? grant_id : pick_idx;
        cand_valid = locked ? req_valid[grant_id] : pick_any;
        req_ready  = '0;
        if (state == IDLE && tx_ready && cand_valid) begin
            req_ready[sel] = 1'b1;
        end
        capture = |req_ready;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (capture)   state_nx = START;
            START:   if (!tx_ready) state_nx = BUSY;
            BUSY:    if (tx_ready)  state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            grant_id  <= '0;
            locked    <= 1'b0;
            rr_ptr    <= '0;
            idle_cnt  <= '0;
            done_seen <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    // Capture takes precedence over a timeout on the same cycle.
                    if (capture) begin
                        tx_data  <= req_data[sel*WIDTH +: WIDTH];
                        grant_id <= sel;
                        locked   <= !req_last[sel];
                        tx_start <= 1'b1;
                        idle_cnt <= '0;
                        if (req_last[sel]) begin
                            rr_ptr <= wrap_inc(sel);
                        end
                    end else if (locked && !req_valid[grant_id]) begin
                        if (idle_cnt == CNT_W'(LOCK_IDLE_MAX - 1)) begin
                            locked   <= 1'b0;
                            rr_ptr   <= wrap_inc(grant_id);
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else if (!locked) begin
                        idle_cnt <= '0;
                    end
                end
                START: begin
                    if (!tx_ready) begin
                        tx_start <= 1'b0;
                    end
                end
                BUSY: begin
                    if (tx_done) begin
                        done_seen <= done_seen + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter that
// stays not-ready for TX_CYC cycles per byte.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ       = 4;
    localparam int unsigned WIDTH         = 8;
    localparam int unsigned LOCK_IDLE_MAX = 16;
    localparam int          TX_CYC        = 20;

    logic                       clock = 1'b0;
    logic                       resetn = 1'b0;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0]   req_data = '0;
    logic [NUM_REQ-1:0]         req_last = '0;
    logic [NUM_REQ-1:0]         req_ready;
    logic [WIDTH-1:0]           tx_data;
    logic                       tx_start;
    logic                       tx_ready;
    logic                       tx_done;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                       locked;
    logic                       busy;

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .WIDTH         (WIDTH),
        .LOCK_IDLE_MAX (LOCK_IDLE_MAX)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_ready  (tx_ready),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .locked    (locked),
        .busy      (busy)
    );

    initial forever #5 clock = ~clock;

    // Transmitter model: samples start while ready, then busy for TX_CYC cycles.
    int         busy_cnt;
    logic [7:0] tx_log[$];
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
            busy_cnt <= 0;
        end else begin
            tx_done <= 1'b0;
            if (tx_ready) begin
                if (tx_start) begin
                    tx_ready <= 1'b0;
                    busy_cnt <= TX_CYC;
                    tx_log.push_back(tx_data);
                end
            end else if (busy_cnt == 1) begin
                tx_ready <= 1'b1;
                tx_done  <= 1'b1;
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    // Producer queues: {last, data}
    logic [8:0] pq[NUM_REQ][$];
    int         grant_log[$];
    logic [7:0] data_log[$];
    int         cap_cyc[$];
    logic       lock_log[$];
    int         cyc;
    int         start_hi, ready_hi0, lock_idle_hi, viol;
    logic       prev_start;
    int         n_checks = 0;
    int         n_errors = 0;
    int         tx_base;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pq[i].size() > 0) begin
                req_valid[i]                = 1'b1;
                req_last[i]                 = pq[i][0][8];
                req_data[i*WIDTH +: WIDTH]  = pq[i][0][7:0];
            end
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pq[i].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step();
        logic [NUM_REQ-1:0] cap;
        @(negedge clock);
        cap = req_ready & req_valid;
        if (tx_start) start_hi++;
        if (req_ready[0]) ready_hi0++;
        if (!busy && locked) lock_idle_hi++;
        if (tx_start && !prev_start && !tx_ready) viol++;
        if (cap != '0 && !$onehot(cap)) viol++;
        prev_start = tx_start;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cap[i]) begin
                grant_log.push_back(i);
                data_log.push_back(req_data[i*WIDTH +: WIDTH]);
                lock_log.push_back(locked);
                cap_cyc.push_back(cyc);
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cap[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        drive();
        cyc++;
    endtask

    task automatic wait_caps(input string tag, input int n, input int limit);
        int k;
        k = 0;
        while (grant_log.size() < n && k < limit) begin
            step();
            k++;
        end
        check_eq({tag, "_capture_timeout"}, 32'(grant_log.size() >= n), 32'd1);
    endtask

    task automatic run_drain(input string tag, input int limit);
        int k;
        k = 0;
        while ((pending() || busy || !tx_ready) && k < limit) begin
            step();
            k++;
        end
        check_eq({tag, "_drain_timeout"}, 32'(k < limit), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_tx_start"},  32'(tx_start),  32'd0);
        check_eq({tag, "_tx_data"},   32'(tx_data),   32'd0);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_grant_id"},  32'(grant_id),  32'd0);
        check_eq({tag, "_locked"},    32'(locked),    32'd0);
        check_eq({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
        drive();
        grant_log.delete();
        data_log.delete();
        cap_cyc.delete();
        lock_log.delete();
        start_hi     = 0;
        ready_hi0    = 0;
        lock_idle_hi = 0;
        viol         = 0;
        prev_start   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        resetn  = 1'b1;
        tx_base = tx_log.size();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_reset_vals("rst");
        do_reset();

        // Single byte from req0
        pq[0].push_back({1'b1, 8'h55});
        drive();
        wait_caps("single", 1, 50);
        run_drain("single", 100);
        check_eq("single_grant",    32'(grant_log[0]), 32'd0);
        check_eq("single_data",     32'(data_log[0]),  32'h55);
        check_eq("single_tx_data",  32'(tx_data),      32'h55);
        check_eq("single_grant_id", 32'(grant_id),     32'd0);
        check_eq("single_start_hi", 32'(start_hi),     32'd2);
        check_eq("single_ready_hi", 32'(ready_hi0),    32'd1);
        check_eq("single_tx_byte",  32'(tx_log[tx_base]), 32'h55);
        check_eq("single_rr_ptr",   32'(dut.rr_ptr),   32'd1);
        check_eq("single_locked",   32'(locked),       32'd0);

        // Fairness: all valid, two single-byte frames each
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < 2; k++) pq[i].push_back({1'b1, 8'(16*i + k)});
        end
        drive();
        wait_caps("fair", 5, 400);
        run_drain("fair", 400);
        check_eq("fair_g0",    32'(grant_log[0]), 32'd0);
        check_eq("fair_g1",    32'(grant_log[1]), 32'd1);
        check_eq("fair_g2",    32'(grant_log[2]), 32'd2);
        check_eq("fair_g3",    32'(grant_log[3]), 32'd3);
        check_eq("fair_g4",    32'(grant_log[4]), 32'd0);
        check_eq("fair_d1",    32'(data_log[1]),  32'h10);
        check_eq("fair_d4",    32'(data_log[4]),  32'h01);
        check_eq("fair_gap",   32'(cap_cyc[1] - cap_cyc[0]), 32'(TX_CYC + 3));
        check_eq("fair_count", 32'(grant_log.size()), 32'd8);
        check_eq("fair_viol",  32'(viol), 32'd0);

        // Frame lock: req2 three-byte frame while req1 and req3 wait
        do_reset();
        pq[2].push_back({1'b0, 8'hA1});
        pq[2].push_back({1'b0, 8'hA2});
        pq[2].push_back({1'b1, 8'hA3});
        drive();
        wait_caps("lock", 1, 50);
        pq[1].push_back({1'b1, 8'hB1});
        pq[3].push_back({1'b1, 8'hD3});
        drive();
        wait_caps("lock", 5, 500);
        run_drain("lock", 200);
        check_eq("lock_g1",  32'(grant_log[1]), 32'd2);
        check_eq("lock_g2",  32'(grant_log[2]), 32'd2);
        check_eq("lock_d2",  32'(data_log[2]),  32'hA3);
        check_eq("lock_l1",  32'(lock_log[1]),  32'd1);
        check_eq("lock_l2",  32'(lock_log[2]),  32'd1);
        check_eq("lock_l3",  32'(lock_log[3]),  32'd0);
        check_eq("lock_g3",  32'(grant_log[3]), 32'd3);
        check_eq("lock_g4",  32'(grant_log[4]), 32'd1);
        check_eq("lock_viol", 32'(viol), 32'd0);

        // Lock timeout: req1 opens a frame and goes quiet, req0 waits
        do_reset();
        pq[1].push_back({1'b0, 8'h11});
        drive();
        wait_caps("tmo", 1, 50);
        pq[0].push_back({1'b1, 8'h20});
        drive();
        wait_caps("tmo", 2, 200);
        run_drain("tmo", 100);
        check_eq("tmo_g1",      32'(grant_log[1]), 32'd0);
        check_eq("tmo_d1",      32'(data_log[1]),  32'h20);
        check_eq("tmo_gap",     32'(cap_cyc[1] - cap_cyc[0]), 32'(TX_CYC + 2 + LOCK_IDLE_MAX + 1));
        check_eq("tmo_idle_hi", 32'(lock_idle_hi), 32'(LOCK_IDLE_MAX));
        check_eq("tmo_l1",      32'(lock_log[1]),  32'd0);
        check_eq("tmo_rr_ptr",  32'(dut.rr_ptr),   32'd1);

        // Reset during req3's byte while its frame is locked
        do_reset();
        pq[3].push_back({1'b0, 8'hC3});
        drive();
        wait_caps("rstmid", 1, 50);
        repeat (5) step();
        check_eq("rstmid_pre_busy",   32'(busy),   32'd1);
        check_eq("rstmid_pre_locked", 32'(locked), 32'd1);
        check_eq("rstmid_pre_grant",  32'(grant_id), 32'd3);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_vals("rstmid");
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) pq[i].push_back({1'b1, 8'(8'hE0 + i)});
        drive();
        wait_caps("rstmid", 1, 50);
        check_eq("rstmid_first_grant", 32'(grant_log[0]), 32'd0);
        check_eq("rstmid_first_data",  32'(data_log[0]),  32'hE0);
        run_drain("rstmid", 400);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
